// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: instruction field ranges,
// opcode/funct constants, forward-select codes, Tuse/Tnew values,
// multiply/divide latencies and the shadow-pipeline record.
package hazard_ctrl_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Tuse: cycles until the value is consumed; Tnew: cycles until produced
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TNEW_LINK   = 2'd0;
  localparam logic [1:0] TNEW_ALU    = 2'd1;
  localparam logic [1:0] TNEW_LOAD   = 2'd2;

  localparam int FWD_W = 3;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF    = 3'd0,
    FWD_PC4_E = 3'd1,
    FWD_AO    = 3'd2,
    FWD_PC4_M = 3'd3,
    FWD_WD    = 3'd4
  } fwd_sel_e;

  localparam logic [3:0] MD_LAT_MULT = 4'd5;
  localparam logic [3:0] MD_LAT_DIV  = 4'd10;

  // MD_MULT / MD_DIV start the unit; MD_ACCESS only touches HI/LO
  typedef enum logic [1:0] {
    MD_NONE   = 2'd0,
    MD_MULT   = 2'd1,
    MD_DIV    = 2'd2,
    MD_ACCESS = 2'd3
  } md_kind_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       link;
    md_kind_e   md;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{rs: 5'd0, rt: 5'd0, a3: 5'd0,
                                        tnew: 2'd0, link: 1'b0, md: MD_NONE};

  function automatic logic md_is_start(input md_kind_e md);
    return (md == MD_MULT) || (md == MD_DIV);
  endfunction

  // One stage older: Tnew counts down and stops at zero
  function automatic shadow_t age_stage(input shadow_t s);
    shadow_t r;
    r = s;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller: the
// D-stage instruction in, forward selects and stall/flush controls out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [31:0]      IRD;
  logic [FWD_W-1:0] Forward_RS_D_Sel;
  logic [FWD_W-1:0] Forward_RT_D_Sel;
  logic [FWD_W-1:0] Forward_RS_E_Sel;
  logic [FWD_W-1:0] Forward_RT_E_Sel;
  logic             StallF;
  logic             StallD;
  logic             FlushE;
  logic             MdBusy;

  modport master (
    output IRD,
    input  Forward_RS_D_Sel, Forward_RT_D_Sel,
    input  Forward_RS_E_Sel, Forward_RT_E_Sel,
    input  StallF, StallD, FlushE, MdBusy
  );

  modport slave (
    input  IRD,
    output Forward_RS_D_Sel, Forward_RT_D_Sel,
    output Forward_RS_E_Sel, Forward_RT_E_Sel,
    output StallF, StallD, FlushE, MdBusy
  );

endinterface

// File: rtl/hazard_ctrl_decode.sv
// Instruction classifier: which registers an instruction reads and when
// it needs them, which register it writes and when the result exists,
// and how it interacts with the multiply/divide unit. Registers that are
// not read report as $0 so they never match a producer.
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] ird,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  a3,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew,
  output logic        link,
  output md_kind_e    md
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic       unused_shamt;

  assign op           = ird[OP_HI:OP_LO];
  assign fn           = ird[FN_HI:FN_LO];
  assign f_rs         = ird[RS_HI:RS_LO];
  assign f_rt         = ird[RT_HI:RT_LO];
  assign f_rd         = ird[RD_HI:RD_LO];
  assign unused_shamt = ^ird[SH_HI:SH_LO];

  // Map each supported instruction to its read/write timing class
  always_comb begin
    rs      = REG_ZERO;
    rt      = REG_ZERO;
    a3      = REG_ZERO;
    tuse_rs = TUSE_ALU;
    tuse_rt = TUSE_ALU;
    tnew    = 2'd0;
    link    = 1'b0;
    md      = MD_NONE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            rs   = f_rs;
            rt   = f_rt;
            a3   = f_rd;
            tnew = TNEW_ALU;
          end
          FN_JR: begin
            rs      = f_rs;
            tuse_rs = TUSE_BRANCH;
          end
          FN_MULT, FN_MULTU: begin
            rs = f_rs;
            rt = f_rt;
            md = MD_MULT;
          end
          FN_DIV, FN_DIVU: begin
            rs = f_rs;
            rt = f_rt;
            md = MD_DIV;
          end
          FN_MFHI, FN_MFLO: begin
            a3   = f_rd;
            tnew = TNEW_ALU;
            md   = MD_ACCESS;
          end
          FN_MTHI, FN_MTLO: begin
            rs = f_rs;
            md = MD_ACCESS;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        rs   = f_rs;
        a3   = f_rt;
        tnew = TNEW_ALU;
      end
      OP_LUI: begin
        a3   = f_rt;
        tnew = TNEW_ALU;
      end
      OP_LW: begin
        rs   = f_rs;
        a3   = f_rt;
        tnew = TNEW_LOAD;
      end
      OP_SW: begin
        rs      = f_rs;
        rt      = f_rt;
        tuse_rt = TUSE_STORE;
      end
      OP_BEQ: begin
        rs      = f_rs;
        rt      = f_rt;
        tuse_rs = TUSE_BRANCH;
        tuse_rt = TUSE_BRANCH;
      end
      OP_JAL: begin
        a3   = REG_RA;
        tnew = TNEW_LINK;
        link = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: classifies the D-stage instruction, tracks the
// classes of the instructions in E/M/W in a shadow pipeline, and from
// those derives forwarding selects, stall/flush controls and the
// multiply/divide busy counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  hazard_ctrl_if.slave  hz
);

  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] d_a3;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [1:0] d_tnew;
  logic       d_link;
  md_kind_e   d_md;

  shadow_t    d_class;
  shadow_t    e_q;
  shadow_t    m_q;
  shadow_t    w_q;
  logic [3:0] md_cnt_q;
  logic       md_busy;
  logic       data_stall;
  logic       md_stall;
  logic       stall;
  logic       w_unused;

  hazard_decode u_decode (
    .ird     (hz.IRD),
    .rs      (d_rs),
    .rt      (d_rt),
    .a3      (d_a3),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .tnew    (d_tnew),
    .link    (d_link),
    .md      (d_md)
  );

  assign d_class = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew,
                     link: d_link, md: d_md};
  assign md_busy = (md_cnt_q != 4'd0);

  // W keeps the full record for a complete trace; only its A3 feeds forwarding
  assign w_unused = ^{w_q.rs, w_q.rt, w_q.tnew, w_q.link, w_q.md};

  function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input shadow_t e, input shadow_t m);
    return (src != REG_ZERO) &&
           (((src == e.a3) && (e.tnew > tuse)) || ((src == m.a3) && (m.tnew > tuse)));
  endfunction

  function automatic fwd_sel_e fwd_d(input logic [4:0] src, input shadow_t e,
                                     input shadow_t m, input shadow_t w);
    if (src == REG_ZERO) return FWD_RF;
    if ((src == e.a3) && (e.tnew == 2'd0) && e.link) return FWD_PC4_E;
    if ((src == m.a3) && (m.tnew == 2'd0)) return m.link ? FWD_PC4_M : FWD_AO;
    if (src == w.a3) return FWD_WD;
    return FWD_RF;
  endfunction

  function automatic fwd_sel_e fwd_e(input logic [4:0] src, input shadow_t m,
                                     input shadow_t w);
    if (src == REG_ZERO) return FWD_RF;
    if ((src == m.a3) && (m.tnew == 2'd0)) return m.link ? FWD_PC4_M : FWD_AO;
    if (src == w.a3) return FWD_WD;
    return FWD_RF;
  endfunction

  // Stall when a needed value is not ready yet or the md unit is occupied
  always_comb begin
    data_stall = reg_hazard(d_rs, d_tuse_rs, e_q, m_q) ||
                 reg_hazard(d_rt, d_tuse_rt, e_q, m_q);
    md_stall   = (d_md != MD_NONE) && (md_is_start(e_q.md) || md_busy);
    stall      = data_stall || md_stall;
  end

  // Drive outputs, held quiet while reset is asserted
  always_comb begin
    hz.Forward_RS_D_Sel = FWD_RF;
    hz.Forward_RT_D_Sel = FWD_RF;
    hz.Forward_RS_E_Sel = FWD_RF;
    hz.Forward_RT_E_Sel = FWD_RF;
    hz.StallF           = 1'b0;
    hz.StallD           = 1'b0;
    hz.FlushE           = 1'b0;
    hz.MdBusy           = 1'b0;
    if (!Reset) begin
      hz.Forward_RS_D_Sel = fwd_d(d_rs, e_q, m_q, w_q);
      hz.Forward_RT_D_Sel = fwd_d(d_rt, e_q, m_q, w_q);
      hz.Forward_RS_E_Sel = fwd_e(e_q.rs, m_q, w_q);
      hz.Forward_RT_E_Sel = fwd_e(e_q.rt, m_q, w_q);
      hz.StallF           = stall;
      hz.StallD           = stall;
      hz.FlushE           = stall;
      hz.MdBusy           = md_busy;
    end
  end

  // Advance the shadow pipeline; a stall injects a bubble into E
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      e_q <= SHADOW_BUBBLE;
      m_q <= SHADOW_BUBBLE;
      w_q <= SHADOW_BUBBLE;
    end else begin
      e_q <= stall ? SHADOW_BUBBLE : d_class;
      m_q <= age_stage(e_q);
      w_q <= age_stage(m_q);
    end
  end

  // Busy counter: a start in E (re)loads the latency, otherwise count down
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      case (e_q.md)
        MD_MULT: md_cnt_q <= MD_LAT_MULT;
        MD_DIV:  md_cnt_q <= MD_LAT_DIV;
        default: if (md_cnt_q != 4'd0) md_cnt_q <= md_cnt_q - 4'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, link, md-busy and
// reset scenarios with hand-computed stall and forward-select values.
module tb_hazard_ctrl;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op);
    return {op, 26'h000_0010};
  endfunction

  task automatic applyStimulus(input logic [31:0] instr);
    @(posedge Clk);
    #1;
    hz.IRD = instr;
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic stall,
                             input logic [2:0] rsD, input logic [2:0] rtD,
                             input logic [2:0] rsE, input logic [2:0] rtE,
                             input logic busy);
    checkVal({tag, ".StallF"}, {2'b00, hz.StallF}, {2'b00, stall});
    checkVal({tag, ".StallD"}, {2'b00, hz.StallD}, {2'b00, stall});
    checkVal({tag, ".FlushE"}, {2'b00, hz.FlushE}, {2'b00, stall});
    checkVal({tag, ".RS_D"}, hz.Forward_RS_D_Sel, rsD);
    checkVal({tag, ".RT_D"}, hz.Forward_RT_D_Sel, rtD);
    checkVal({tag, ".RS_E"}, hz.Forward_RS_E_Sel, rsE);
    checkVal({tag, ".RT_E"}, hz.Forward_RT_E_Sel, rtE);
    checkVal({tag, ".MdBusy"}, {2'b00, hz.MdBusy}, {2'b00, busy});
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) applyStimulus(NOP);
  endtask

  initial begin
    Reset  = 1'b1;
    hz.IRD = encR(5'd1, 5'd1, 5'd2, 6'h21);
    #3;
    checkOutput("reset", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    #4;
    Reset  = 1'b0;
    hz.IRD = NOP;
    drain();

    $display("[TB] load-use: lw $1 then addu $2,$1,$1");
    applyStimulus(encI(6'h23, 5'd0, 5'd1, 16'h0000));
    checkOutput("lw_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd1, 5'd1, 5'd2, 6'h21));
    checkOutput("lu_stall", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd1, 5'd1, 5'd2, 6'h21));
    checkOutput("lu_release", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(NOP);
    checkOutput("lu_fwd_e", 1'b0, 3'd0, 3'd0, 3'd4, 3'd4, 1'b0);
    drain();

    $display("[TB] branch: addu $3 then beq $3,$3");
    applyStimulus(encR(5'd4, 5'd5, 5'd3, 6'h21));
    checkOutput("alu_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h04, 5'd3, 5'd3, 16'h0004));
    checkOutput("beq_stall", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h04, 5'd3, 5'd3, 16'h0004));
    checkOutput("beq_fwd_ao", 1'b0, 3'd2, 3'd2, 3'd0, 3'd0, 1'b0);
    applyStimulus(NOP);
    checkOutput("beq_e_wd", 1'b0, 3'd0, 3'd0, 3'd4, 3'd4, 1'b0);
    drain();

    $display("[TB] link: jal then jr $31 three times");
    applyStimulus(encJ(6'h03));
    checkOutput("jal_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd31, 5'd0, 5'd0, 6'h08));
    checkOutput("jr_pc4e", 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd31, 5'd0, 5'd0, 6'h08));
    checkOutput("jr_pc4m", 1'b0, 3'd3, 3'd0, 3'd3, 3'd0, 1'b0);
    applyStimulus(encR(5'd31, 5'd0, 5'd0, 6'h08));
    checkOutput("jr_wd", 1'b0, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0);
    drain();

    $display("[TB] zero register: addu $0 then addu $2,$0,$0");
    applyStimulus(encR(5'd1, 5'd1, 5'd0, 6'h21));
    checkOutput("zero_wr", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd0, 5'd0, 5'd2, 6'h21));
    checkOutput("zero_rd", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(NOP);
    checkOutput("zero_e", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    drain();

    $display("[TB] ALU chain, store boundary, lui then beq");
    applyStimulus(encR(5'd4, 5'd5, 5'd6, 6'h21));
    checkOutput("chain_a", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd6, 5'd6, 5'd7, 6'h21));
    checkOutput("chain_b", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h23, 5'd0, 5'd9, 16'h0000));
    checkOutput("chain_e_ao", 1'b0, 3'd0, 3'd0, 3'd2, 3'd2, 1'b0);
    applyStimulus(encI(6'h2b, 5'd0, 5'd9, 16'h0000));
    checkOutput("sw_after_lw", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h0f, 5'd0, 5'd10, 16'h0001));
    checkOutput("lui_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h04, 5'd10, 5'd0, 16'h0004));
    checkOutput("lui_beq_stall", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encI(6'h04, 5'd10, 5'd0, 16'h0004));
    checkOutput("lui_beq_ao", 1'b0, 3'd2, 3'd0, 3'd0, 3'd0, 1'b0);
    drain();

    $display("[TB] divide: div then mflo");
    applyStimulus(encR(5'd4, 5'd5, 5'd0, 6'h1a));
    checkOutput("div_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
    checkOutput("div_start", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 2; i <= 11; i++) begin
      applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
      checkOutput($sformatf("div_busy%0d", i), 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
    checkOutput("div_done", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    drain();

    $display("[TB] multiply: mult then mfhi");
    applyStimulus(encR(5'd4, 5'd5, 5'd0, 6'h18));
    checkOutput("mult_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h10));
    checkOutput("mult_start", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h10));
      checkOutput($sformatf("mult_busy%0d", i), 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h10));
    checkOutput("mult_done", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    drain();

    $display("[TB] reset pulse in the middle of a divide");
    applyStimulus(encR(5'd4, 5'd5, 5'd0, 6'h1b));
    checkOutput("divu_d", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
    checkOutput("divu_start", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
    end
    checkOutput("divu_cnt6", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    Reset = 1'b1;
    #1;
    checkOutput("rst_mid", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    Reset = 1'b0;
    #1;
    checkOutput("rst_release", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(encR(5'd0, 5'd0, 5'd8, 6'h12));
    checkOutput("rst_after", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    applyStimulus(NOP);
    checkOutput("rst_after2", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port IRD, input, 32, instruction in D stage.
REQ-004 SHALL have ports Forward_RS_D_Sel / Forward_RT_D_Sel, output, 3 each, D-stage forward select.
REQ-005 SHALL have ports Forward_RS_E_Sel / Forward_RT_E_Sel, output, 3 each, E-stage forward select.
REQ-006 SHALL have port StallF, output, 1, freeze PC.
REQ-007 SHALL have port StallD, output, 1, freeze D register.
REQ-008 SHALL have port FlushE, output, 1, bubble into E register.
REQ-009 SHALL have port MdBusy, output, 1, multiply/divide unit occupied.
REQ-010 SHALL use forward encoding 0=RF, 1=PC4 from E (link), 2=AO, 3=PC4 from M (link), 4=Wd (W); 5-7 unused.

Function
REQ-011 SHALL classify IRD combinationally into rs/rt Tuse, destination A3, Tnew at E, link flag and md class. Set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
REQ-012 SHALL use Tuse 0 for beq rs/rt and jr rs, 2 for sw rt, 1 for all other reads.
REQ-013 SHALL use Tnew at E of 0 for jal (A3=31, link), 2 for lw, 1 for ALU/mfhi/mflo.
REQ-014 SHALL use A3=0 for instructions that do not write the register file.
REQ-015 SHALL keep a shadow pipeline E->M->W of {rs, rt, A3, Tnew, link, md}; each edge: E<=D class (or bubble if FlushE), M<=E, W<=M, Tnew decremented, saturating at 0.
REQ-016 SHALL raise a data stall when a read register src!=0 matches E.A3 with E.Tnew>Tuse, or M.A3 with M.Tnew>Tuse.
REQ-017 SHALL raise an md stall when IRD is md class and (E.md start or MdBusy).
REQ-018 On any stall SHALL assert StallF=StallD=FlushE=1 in the same cycle, combinationally.
REQ-019 SHALL form D forward select by priority: E (Tnew==0, link)->1; M (Tnew==0)->3 if link else 2; W A3 match->4; else 0. src==0 always gives 0.
REQ-020 SHALL form E forward select over the E shadow rs/rt by priority: M->3/2, W->4, else 0.
REQ-021 SHALL load the md counter with 5 (mult/multu) or 10 (div/divu) on the edge where E holds an md start; it SHALL decrement to 0 otherwise; MdBusy = counter!=0.
REQ-022 An md start arriving while the counter is nonzero SHALL be impossible by REQ-017; a reload SHALL overwrite the counter anyway.
REQ-023 Bubbles (FlushE) SHALL enter the shadow as A3=0, md=0.

Reset
REQ-024 Reset SHALL clear all shadow stages to bubble and the md counter to 0 immediately, regardless of clock.
REQ-025 During reset SHALL drive all forward selects 0, StallF=StallD=FlushE=0, MdBusy=0.
REQ-026 Reset mid-divide SHALL drop MdBusy the same cycle; no stall persists after release.

Structure
REQ-027 Shared package (header) SHALL hold opcode/funct constants, field ranges, forward-select codes and md latencies.
REQ-028 The classifier SHALL be one combinational sub-module, hazard_decode, instantiated for IRD only; the shadow stores its outputs.

Verification
REQ-029 lw $1,0($0); then addu $2,$1,$1 in D -> one cycle StallF/StallD/FlushE=1; next cycle Forward_RS_D_Sel=4 after W... E-stage select=4 for rs and rt.
REQ-030 addu $3,$4,$5; then beq $3,$3 in D -> one stall cycle, then Forward_RS_D_Sel=Forward_RT_D_Sel=2.
REQ-031 jal; then jr $31 in D -> no stall; Forward_RS_D_Sel=1.
REQ-032 div, then mflo in D -> stall 11 cycles (start in E plus 10 busy); MdBusy high exactly 10 cycles.
REQ-033 addu $0,$1,$1; then addu $2,$0,$0 -> no stall, all selects 0.
REQ-034 Assert Reset for 1 ns mid-divide at count 6 -> MdBusy=0 and StallF=0 immediately; shadow empty.
